// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: a Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Outputs are combinational from the state register plus op, memReady and zero.
module mips_mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       memReady,
  input  logic       zero,
  output logic [1:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       PCEn,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       illegalOp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e state_q, state_d;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path can infer a latch.
    state_d   = state_q;
    ALUop     = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    PCEn      = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    illegalOp = 1'b0;

    unique case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = memReady;
        PCEn    = memReady;
        if (memReady) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_RTYPE:         state_d = EXEC;
          OP_BEQ:           state_d = BRANCH;
          OP_ADDI, OP_SLTI: state_d = IMMEX;
          OP_J:             state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegalOp = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR is stable until the next fetch, so op still names the decoded instruction.
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (memReady) state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (memReady) state_d = FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b01;
        PCSrc   = 2'b01;
        PCEn    = zero;
        state_d = FETCH;
      end
      IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = (op == OP_SLTI) ? 2'b11 : 2'b00;
        state_d = IMMWB;
      end
      IMMWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        PCSrc   = 2'b10;
        PCEn    = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks each instruction class through its state
// sequence, stalls memory, resets mid-instruction and decodes an illegal opcode.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       memReady;
  logic       zero;
  logic [1:0] ALUop;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD, IRWrite, MemWrite, MemRead, PCEn, RegWrite, RegDst, MemtoReg, illegalOp;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .op(op), .memReady(memReady), .zero(zero),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .PCEn(PCEn), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .illegalOp(illegalOp), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 6'b100011; memReady = 1'b1; zero = 1'b0;
    #12;
    check("rst_state", state, 0);
    check("rst_memread", MemRead, 1);
    check("rst_irwrite", IRWrite, 1);
    check("rst_pcen", PCEn, 1);
    check("rst_regwrite", RegWrite, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_illegal", illegalOp, 0);
    memReady = 1'b0; #1;
    check("rst_irwrite_nr", IRWrite, 0);
    check("rst_pcen_nr", PCEn, 0);
    memReady = 1'b1;
    rst = 1'b0;

    // lw: 0,1,2,3,4,0
    tick(); check("lw_s1", state, 1); check("lw_aluop1", ALUop, 0); check("lw_srcb1", ALUSrcB, 3);
    check("lw_rw1", RegWrite, 0);
    tick(); check("lw_s2", state, 2); check("lw_aluop2", ALUop, 0); check("lw_srca2", ALUSrcA, 1);
    check("lw_srcb2", ALUSrcB, 2);
    tick(); check("lw_s3", state, 3); check("lw_rd3", MemRead, 1); check("lw_iord3", IorD, 1);
    check("lw_rw3", RegWrite, 0);
    tick(); check("lw_s4", state, 4); check("lw_rw4", RegWrite, 1); check("lw_m2r4", MemtoReg, 1);
    check("lw_dst4", RegDst, 0);
    tick(); check("lw_s0", state, 0); check("lw_aluop0", ALUop, 0); check("lw_m2r0", MemtoReg, 0);

    // sw with three stalled MEMWR cycles
    op = 6'b101011;
    tick(); check("sw_s1", state, 1);
    tick(); check("sw_s2", state, 2);
    memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sw_wait_state", state, 5);
      check("sw_wait_mw", MemWrite, 1);
      check("sw_wait_rw", RegWrite, 0);
    end
    memReady = 1'b1; #1;
    check("sw_last_state", state, 5);
    check("sw_last_mw", MemWrite, 1);
    tick(); check("sw_done", state, 0);

    // FETCH stall, then beq taken and not taken
    memReady = 1'b0;
    tick(); check("fetch_stall", state, 0); check("fetch_stall_ir", IRWrite, 0);
    memReady = 1'b1; op = 6'b000100; zero = 1'b1;
    tick(); check("beq1_s1", state, 1);
    tick(); check("beq1_s8", state, 8); check("beq1_pcen", PCEn, 1); check("beq1_pcsrc", PCSrc, 1);
    check("beq1_aluop", ALUop, 1);
    tick(); check("beq1_s0", state, 0);
    zero = 1'b0;
    tick(); check("beq0_s1", state, 1);
    tick(); check("beq0_s8", state, 8); check("beq0_pcen", PCEn, 0);
    tick(); check("beq0_s0", state, 0);

    // R-type then slti back to back
    op = 6'b000000;
    tick(); check("r_s1", state, 1);
    tick(); check("r_s6", state, 6); check("r_aluop", ALUop, 2); check("r_srcb", ALUSrcB, 0);
    tick(); check("r_s7", state, 7); check("r_dst", RegDst, 1); check("r_rw", RegWrite, 1);
    tick(); check("r_s0", state, 0);
    op = 6'b001010;
    tick(); check("slti_s1", state, 1);
    tick(); check("slti_s9", state, 9); check("slti_aluop", ALUop, 3);
    tick(); check("slti_s10", state, 10); check("slti_dst", RegDst, 0); check("slti_rw", RegWrite, 1);
    tick(); check("slti_s0", state, 0);

    // addi uses add in IMMEX
    op = 6'b001000;
    tick(); check("addi_s1", state, 1);
    tick(); check("addi_s9", state, 9); check("addi_aluop", ALUop, 0);
    tick(); check("addi_s10", state, 10);
    tick(); check("addi_s0", state, 0);

    // illegal opcode
    op = 6'b111111;
    tick(); check("ill_s1", state, 1); check("ill_pulse", illegalOp, 1);
    check("ill_rw", RegWrite, 0); check("ill_mw", MemWrite, 0); check("ill_pcen", PCEn, 0);
    tick(); check("ill_s0", state, 0); check("ill_off", illegalOp, 0);

    // j
    op = 6'b000010;
    tick(); check("j_s1", state, 1);
    tick(); check("j_s11", state, 11); check("j_pcen", PCEn, 1); check("j_pcsrc", PCSrc, 2);
    tick(); check("j_s0", state, 0);

    // asynchronous reset in the middle of EXEC
    op = 6'b000000;
    tick(); check("rx_s1", state, 1);
    tick(); check("rx_s6", state, 6);
    #2 rst = 1'b1;
    #1;
    check("rx_state", state, 0);
    check("rx_rw", RegWrite, 0);
    check("rx_memread", MemRead, 1);
    @(negedge clk);
    rst = 1'b0;
    tick(); check("rx_decode", state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle main control unit for the MIPS core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps. It sits directly upstream of the ALU decoder and drives its 2-bit `ALUop`, along with every datapath mux select and write enable. Memory accesses use a ready handshake so the core works with multi-cycle memory.

## Interface
Parameters:
- none. Opcodes are fixed: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, slti 001010, j 000010.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  6  opcode, taken from the instruction register (`instr[31:26]`).
- `memReady`  in  1  memory has completed the current read or write this cycle.
- `zero`  in  1  ALU zero flag.
- `ALUop`  out  2  goes to the ALU decoder. 00 = add, 01 = sub, 10 = use funct, 11 = slt.
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSrc`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `IorD`  out  1  memory address select. 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  instruction register write enable.
- `MemWrite`  out  1  memory write request.
- `MemRead`  out  1  memory read request.
- `PCEn`  out  1  PC write enable.
- `RegWrite`  out  1  register file write enable.
- `RegDst`  out  1  0 = rt, 1 = rd.
- `MemtoReg`  out  1  0 = ALUOut, 1 = memory data register.
- `illegalOp`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `state`  out  4  current state encoding, for debug.

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11.
- Encodings 12–15 are unreachable. If entered, the next state is FETCH.

Default output values:
- Every output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH:
  - Outputs: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUop`=00, `PCSrc`=00.
  - `IRWrite` = `memReady` and `PCEn` = `memReady`.
  - Stays in FETCH while `memReady`=0. Goes to DECODE when `memReady`=1.
- DECODE:
  - Outputs: `ALUSrcA`=0, `ALUSrcB`=11, `ALUop`=00. This precomputes the branch target.
  - Next state by `op`: lw/sw → MEMADR, R-type → EXEC, beq → BRANCH, addi/slti → IMMEX, j → JUMP.
  - Any other opcode → FETCH, with `illegalOp`=1 during this DECODE cycle.
- MEMADR:
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00.
  - Next state: lw → MEMRD, sw → MEMWR.
- MEMRD:
  - Outputs: `MemRead`=1, `IorD`=1.
  - Waits for `memReady`, then goes to MEMWB.
- MEMWB:
  - Outputs: `RegWrite`=1, `RegDst`=0, `MemtoReg`=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: `MemWrite`=1, `IorD`=1.
  - Waits for `memReady`, then goes to FETCH.
- EXEC:
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0.
  - Next state: FETCH.
- BRANCH:
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=01, `PCSrc`=01, `PCEn`=`zero`.
  - Next state: FETCH.
- IMMEX:
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00 for addi, 11 for slti.
  - Next state: IMMWB.
- IMMWB:
  - Outputs: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.
  - Next state: FETCH.
- JUMP:
  - Outputs: `PCSrc`=10, `PCEn`=1.
  - Next state: FETCH.

Handshake and decode rules:
- `MemRead` and `MemWrite` stay high and unchanged until the cycle in which `memReady`=1.
- `memReady` is ignored in every state other than FETCH, MEMRD and MEMWR.
- In every state after DECODE, decisions use `op` as it stands, because IR is stable until the next FETCH completes.

## Timing
- Reset: `rst` high forces `state` to FETCH immediately, with no clock edge needed.
  - `MemRead`=1 follows from FETCH decode.
  - `IRWrite` and `PCEn` follow `memReady`.
  - All write enables other than those are 0.
  - `illegalOp`=0.
- Reset mid-instruction aborts the instruction. No register or memory write occurs after `rst` rises.
- The state register updates on the rising edge of `clk`. All outputs are combinational from `state`, `op`, `memReady` and `zero`; none is registered.
- Cycle counts with `memReady` held at 1:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - addi/slti: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - illegal: 2 cycles.
- Each cycle in which `memReady`=0 during FETCH, MEMRD or MEMWR adds one cycle to the instruction.
- `illegalOp` is exactly 1 cycle wide per illegal opcode.

## Test plan
- Reset: assert `rst` asynchronously mid-EXEC → `state`=0 before the next `clk` edge, `RegWrite`=0. Release `rst` with `memReady`=1 → DECODE after 1 edge.
- lw with `memReady` tied to 1 → state sequence 0,1,2,3,4,0. `RegWrite`=1 and `MemtoReg`=1 only in state 4. `ALUop`=00 in states 0, 1 and 2.
- sw with `memReady` low for 3 cycles in MEMWR → `MemWrite`=1 held for 4 cycles. Returns to FETCH on the edge after `memReady`=1. `RegWrite` never set.
- beq:
  - `zero`=1 → `PCEn`=1, `PCSrc`=01, `ALUop`=01 in BRANCH.
  - `zero`=0 → `PCEn`=0.
  - Both cases: 3 cycles total.
- R-type then slti back-to-back:
  - R-type: `ALUop`=10 in EXEC, `RegDst`=1 in ALUWB.
  - slti: `ALUop`=11 in IMMEX, `RegDst`=0 in IMMWB.
- op=111111 → `illegalOp` high for exactly 1 cycle in DECODE, next state FETCH. No `RegWrite`, `MemWrite` or `PCEn` asserted.
